// File: rtl/vreg_wb_arbiter.sv
// Write-back arbiter for a 4-entry vector register bank: round-robin over ALU, load and
// immediate writers, a registered bank write port, and a per-register busy scoreboard.
module vreg_wb_arbiter #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   // requester 0: vector ALU, full-vector write
   input  logic              i_alu_valid,
   output logic              o_alu_ready,
   input  logic [1:0]        i_alu_vd,
   input  logic [DATA_W-1:0] i_alu_w1,
   input  logic [DATA_W-1:0] i_alu_w2,
   input  logic [DATA_W-1:0] i_alu_w3,
   input  logic [DATA_W-1:0] i_alu_w4,
   // requester 1: vector load, full-vector write
   input  logic              i_ld_valid,
   output logic              o_ld_ready,
   input  logic [1:0]        i_ld_vd,
   input  logic [DATA_W-1:0] i_ld_w1,
   input  logic [DATA_W-1:0] i_ld_w2,
   input  logic [DATA_W-1:0] i_ld_w3,
   input  logic [DATA_W-1:0] i_ld_w4,
   // requester 2: single-lane immediate write
   input  logic              i_im_valid,
   output logic              o_im_ready,
   input  logic [1:0]        i_im_vd,
   input  logic [1:0]        i_im_vindex,
   input  logic [DATA_W-1:0] i_im_imm,
   // issue-side reservation and hazard query
   input  logic              i_rsv_valid,
   output logic              o_rsv_ready,
   input  logic [1:0]        i_rsv_vd,
   input  logic              i_rd_valid,
   input  logic [1:0]        i_vs1,
   input  logic [1:0]        i_vs2,
   output logic              o_hazard,
   // register bank write port
   output logic              o_write_enable,
   output logic              o_write_imm,
   output logic [1:0]        o_vd,
   output logic [1:0]        o_vindex,
   output logic [DATA_W-1:0] o_imm,
   output logic [DATA_W-1:0] o_vw1,
   output logic [DATA_W-1:0] o_vw2,
   output logic [DATA_W-1:0] o_vw3,
   output logic [DATA_W-1:0] o_vw4,
   output logic [3:0]        o_busy
);

   logic [3:0]        r_busy;
   logic [1:0]        r_ptr;
   logic              r_write_enable;
   logic              r_write_imm;
   logic [1:0]        r_vd;
   logic [1:0]        r_vindex;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_vw1;
   logic [DATA_W-1:0] r_vw2;
   logic [DATA_W-1:0] r_vw3;
   logic [DATA_W-1:0] r_vw4;

   logic [2:0]        w_elig;
   logic [2:0]        w_gnt;
   logic [1:0]        w_ptr_d;
   logic              w_rsv_set;
   logic [3:0]        w_busy_d;

   assign w_elig = {i_im_valid & ~r_busy[i_im_vd], i_ld_valid, i_alu_valid};

   // Priority order starts at r_ptr and wraps modulo 3.
   always_comb begin
      w_gnt = 3'b000;
      case (r_ptr)
         2'd1: begin
            if (w_elig[1])      w_gnt = 3'b010;
            else if (w_elig[2]) w_gnt = 3'b100;
            else if (w_elig[0]) w_gnt = 3'b001;
         end
         2'd2: begin
            if (w_elig[2])      w_gnt = 3'b100;
            else if (w_elig[0]) w_gnt = 3'b001;
            else if (w_elig[1]) w_gnt = 3'b010;
         end
         default: begin
            if (w_elig[0])      w_gnt = 3'b001;
            else if (w_elig[1]) w_gnt = 3'b010;
            else if (w_elig[2]) w_gnt = 3'b100;
         end
      endcase
   end

   always_comb begin
      w_ptr_d = r_ptr;
      if (w_gnt[0])      w_ptr_d = 2'd1;
      else if (w_gnt[1]) w_ptr_d = 2'd2;
      else if (w_gnt[2]) w_ptr_d = 2'd0;
   end

   // A reservation landing on the edge where its register retires is taken, so set wins.
   assign w_rsv_set = i_rsv_valid &
                      (~r_busy[i_rsv_vd] | (r_write_enable & (r_vd == i_rsv_vd)));

   always_comb begin
      w_busy_d = r_busy;
      if (r_write_enable) w_busy_d[r_vd] = 1'b0;
      if (w_rsv_set)      w_busy_d[i_rsv_vd] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy         <= 4'b0000;
         r_ptr          <= 2'd0;
         r_write_enable <= 1'b0;
         r_write_imm    <= 1'b0;
         r_vd           <= 2'd0;
         r_vindex       <= 2'd0;
         r_imm          <= '0;
         r_vw1          <= '0;
         r_vw2          <= '0;
         r_vw3          <= '0;
         r_vw4          <= '0;
      end else begin
         r_busy         <= w_busy_d;
         r_ptr          <= w_ptr_d;
         r_write_enable <= w_gnt[0] | w_gnt[1];
         r_write_imm    <= w_gnt[2];
         if (w_gnt[0]) begin
            r_vd  <= i_alu_vd;
            r_vw1 <= i_alu_w1;
            r_vw2 <= i_alu_w2;
            r_vw3 <= i_alu_w3;
            r_vw4 <= i_alu_w4;
         end else if (w_gnt[1]) begin
            r_vd  <= i_ld_vd;
            r_vw1 <= i_ld_w1;
            r_vw2 <= i_ld_w2;
            r_vw3 <= i_ld_w3;
            r_vw4 <= i_ld_w4;
         end else if (w_gnt[2]) begin
            r_vd     <= i_im_vd;
            r_vindex <= i_im_vindex;
            r_imm    <= i_im_imm;
         end
      end
   end

   assign o_alu_ready    = i_rst_n & w_gnt[0];
   assign o_ld_ready     = i_rst_n & w_gnt[1];
   assign o_im_ready     = i_rst_n & w_gnt[2];
   assign o_rsv_ready    = i_rst_n & ~r_busy[i_rsv_vd];
   assign o_hazard       = i_rd_valid & (r_busy[i_vs1] | r_busy[i_vs2]);
   assign o_write_enable = r_write_enable;
   assign o_write_imm    = r_write_imm;
   assign o_vd           = r_vd;
   assign o_vindex       = r_vindex;
   assign o_imm          = r_imm;
   assign o_vw1          = r_vw1;
   assign o_vw2          = r_vw2;
   assign o_vw3          = r_vw3;
   assign o_vw4          = r_vw4;
   assign o_busy         = r_busy;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Directed bench for vreg_wb_arbiter: inputs change after rising edges, registered outputs are
// sampled 1 ns after the edge, combinational outputs 1 ns after the inputs settle.
module tb_vreg_wb_arbiter;

   localparam int unsigned DATA_W = 32;

   logic              clk;
   logic              rst_n;
   logic              alu_valid, alu_ready;
   logic [1:0]        alu_vd;
   logic [DATA_W-1:0] alu_w1, alu_w2, alu_w3, alu_w4;
   logic              ld_valid, ld_ready;
   logic [1:0]        ld_vd;
   logic [DATA_W-1:0] ld_w1, ld_w2, ld_w3, ld_w4;
   logic              im_valid, im_ready;
   logic [1:0]        im_vd, im_vindex;
   logic [DATA_W-1:0] im_imm;
   logic              rsv_valid, rsv_ready;
   logic [1:0]        rsv_vd;
   logic              rd_valid;
   logic [1:0]        vs1, vs2;
   logic              hazard;
   logic              write_enable, write_imm;
   logic [1:0]        vd, vindex;
   logic [DATA_W-1:0] imm, vw1, vw2, vw3, vw4;
   logic [3:0]        busy;

   int n_vec = 0;
   int n_err = 0;

   vreg_wb_arbiter #(.DATA_W(DATA_W)) u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_alu_valid    (alu_valid),
      .o_alu_ready    (alu_ready),
      .i_alu_vd       (alu_vd),
      .i_alu_w1       (alu_w1),
      .i_alu_w2       (alu_w2),
      .i_alu_w3       (alu_w3),
      .i_alu_w4       (alu_w4),
      .i_ld_valid     (ld_valid),
      .o_ld_ready     (ld_ready),
      .i_ld_vd        (ld_vd),
      .i_ld_w1        (ld_w1),
      .i_ld_w2        (ld_w2),
      .i_ld_w3        (ld_w3),
      .i_ld_w4        (ld_w4),
      .i_im_valid     (im_valid),
      .o_im_ready     (im_ready),
      .i_im_vd        (im_vd),
      .i_im_vindex    (im_vindex),
      .i_im_imm       (im_imm),
      .i_rsv_valid    (rsv_valid),
      .o_rsv_ready    (rsv_ready),
      .i_rsv_vd       (rsv_vd),
      .i_rd_valid     (rd_valid),
      .i_vs1          (vs1),
      .i_vs2          (vs2),
      .o_hazard       (hazard),
      .o_write_enable (write_enable),
      .o_write_imm    (write_imm),
      .o_vd           (vd),
      .o_vindex       (vindex),
      .o_imm          (imm),
      .o_vw1          (vw1),
      .o_vw2          (vw2),
      .o_vw3          (vw3),
      .o_vw4          (vw4),
      .o_busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Grant order with all three requesters valid from ptr=0: ALU, load, imm, ALU.
   logic [2:0] exp_gnt [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [1:0] exp_vd  [4] = '{2'd2, 2'd3, 2'd1, 2'd2};

   initial begin
      rst_n = 1'b0;
      alu_valid = 1'b1; alu_vd = 2'd0;
      alu_w1 = '0; alu_w2 = '0; alu_w3 = '0; alu_w4 = '0;
      ld_valid = 1'b0; ld_vd = 2'd0;
      ld_w1 = '0; ld_w2 = '0; ld_w3 = '0; ld_w4 = '0;
      im_valid = 1'b0; im_vd = 2'd0; im_vindex = 2'd0; im_imm = '0;
      rsv_valid = 1'b0; rsv_vd = 2'd0;
      rd_valid = 1'b0; vs1 = 2'd0; vs2 = 2'd0;

      // reset state
      #3;
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_we", 64'(write_enable), 64'h0);
      check("rst_wimm", 64'(write_imm), 64'h0);
      check("rst_vd", 64'(vd), 64'h0);
      check("rst_imm", 64'(imm), 64'h0);
      check("rst_vw1", 64'(vw1), 64'h0);
      check("rst_alu_ready", 64'(alu_ready), 64'h0);
      check("rst_rsv_ready", 64'(rsv_ready), 64'h0);
      alu_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();

      // ALU alone
      alu_valid = 1'b1; alu_vd = 2'd1;
      alu_w1 = 32'h42080000; alu_w2 = 32'h41600000; alu_w3 = 32'h41680000; alu_w4 = 32'h42AACCCD;
      #1;
      check("alu_ready", 64'(alu_ready), 64'h1);
      check("alu_ld_ready", 64'(ld_ready), 64'h0);
      step();
      alu_valid = 1'b0;
      check("alu_we", 64'(write_enable), 64'h1);
      check("alu_wimm", 64'(write_imm), 64'h0);
      check("alu_vd", 64'(vd), 64'h1);
      check("alu_vw1", 64'(vw1), 64'h42080000);
      check("alu_vw2", 64'(vw2), 64'h41600000);
      check("alu_vw3", 64'(vw3), 64'h41680000);
      check("alu_vw4", 64'(vw4), 64'h42AACCCD);
      step();
      check("alu_we_pulse", 64'(write_enable), 64'h0);

      // immediate write; ptr is 1 so this grant returns ptr to 0
      im_valid = 1'b1; im_vd = 2'd0; im_vindex = 2'd3; im_imm = 32'h4059999A;
      #1;
      check("im_ready", 64'(im_ready), 64'h1);
      step();
      im_valid = 1'b0;
      check("im_wimm", 64'(write_imm), 64'h1);
      check("im_we", 64'(write_enable), 64'h0);
      check("im_vd", 64'(vd), 64'h0);
      check("im_vindex", 64'(vindex), 64'h3);
      check("im_imm", 64'(imm), 64'h4059999A);
      check("im_vw1_hold", 64'(vw1), 64'h42080000);
      step();
      check("im_wimm_pulse", 64'(write_imm), 64'h0);

      // all three valid: round-robin from ptr=0
      alu_valid = 1'b1; alu_vd = 2'd2;
      alu_w1 = 32'hA1; alu_w2 = 32'hA2; alu_w3 = 32'hA3; alu_w4 = 32'hA4;
      ld_valid = 1'b1; ld_vd = 2'd3;
      ld_w1 = 32'hB1; ld_w2 = 32'hB2; ld_w3 = 32'hB3; ld_w4 = 32'hB4;
      im_valid = 1'b1; im_vd = 2'd1; im_vindex = 2'd2; im_imm = 32'hC0FFEE;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr_gnt%0d", i), 64'({im_ready, ld_ready, alu_ready}), 64'(exp_gnt[i]));
         step();
         check($sformatf("rr_we%0d", i), 64'(write_enable), 64'(exp_gnt[i][0] | exp_gnt[i][1]));
         check($sformatf("rr_wimm%0d", i), 64'(write_imm), 64'(exp_gnt[i][2]));
         check($sformatf("rr_vd%0d", i), 64'(vd), 64'(exp_vd[i]));
      end
      check("rr_ld_vw4", 64'(vw4), 64'hA4);
      alu_valid = 1'b0; ld_valid = 1'b0; im_valid = 1'b0;
      step();
      check("rr_idle_we", 64'(write_enable), 64'h0);
      check("rr_idle_wimm", 64'(write_imm), 64'h0);

      // scoreboard set, hazard, immediate blocking, clear by full write
      rsv_valid = 1'b1; rsv_vd = 2'd0;
      #1;
      check("sb_rsv_ready", 64'(rsv_ready), 64'h1);
      step();
      rsv_valid = 1'b0;
      check("sb_busy_set", 64'(busy), 64'h1);
      rd_valid = 1'b1; vs1 = 2'd0; vs2 = 2'd1;
      im_valid = 1'b1; im_vd = 2'd0; im_vindex = 2'd0; im_imm = 32'h5;
      #1;
      check("sb_hazard", 64'(hazard), 64'h1);
      check("sb_im_blocked", 64'(im_ready), 64'h0);
      alu_valid = 1'b1; alu_vd = 2'd0;
      #1;
      check("sb_alu_ready", 64'(alu_ready), 64'h1);
      step();
      alu_valid = 1'b0;
      check("sb_we", 64'(write_enable), 64'h1);
      check("sb_busy_before_clr", 64'(busy), 64'h1);
      check("sb_im_still_blocked", 64'(im_ready), 64'h0);
      step();
      check("sb_busy_clr", 64'(busy), 64'h0);
      check("sb_hazard_clr", 64'(hazard), 64'h0);
      check("sb_im_ready", 64'(im_ready), 64'h1);
      im_valid = 1'b0; rd_valid = 1'b0;
      step();

      // set and clear of the same register on one edge
      rsv_valid = 1'b1; rsv_vd = 2'd2;
      step();
      rsv_valid = 1'b0;
      check("sc_busy_set", 64'(busy), 64'h4);
      alu_valid = 1'b1; alu_vd = 2'd2;
      step();
      alu_valid = 1'b0;
      check("sc_we", 64'(write_enable), 64'h1);
      rsv_valid = 1'b1; rsv_vd = 2'd2;
      #1;
      check("sc_rsv_ready_busy", 64'(rsv_ready), 64'h0);
      step();
      check("sc_busy_kept", 64'(busy), 64'h4);
      check("sc_rsv_ready_again", 64'(rsv_ready), 64'h0);
      rsv_valid = 1'b0;
      step();

      // reset in the cycle after an accepted ALU transfer
      alu_valid = 1'b1; alu_vd = 2'd3;
      alu_w1 = 32'hD1; alu_w2 = 32'hD2; alu_w3 = 32'hD3; alu_w4 = 32'hD4;
      step();
      alu_valid = 1'b0;
      check("mr_we_before", 64'(write_enable), 64'h1);
      rst_n = 1'b0;
      #1;
      check("mr_we", 64'(write_enable), 64'h0);
      check("mr_busy", 64'(busy), 64'h0);
      check("mr_vw1", 64'(vw1), 64'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("mr_no_we%0d", i), 64'(write_enable), 64'h0);
         check($sformatf("mr_no_wimm%0d", i), 64'(write_imm), 64'h0);
      end
      // ptr back at 0: ALU wins over load
      alu_valid = 1'b1; ld_valid = 1'b1;
      #1;
      check("mr_ptr_alu", 64'(alu_ready), 64'h1);
      check("mr_ptr_ld", 64'(ld_ready), 64'h0);
      alu_valid = 1'b0; ld_valid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vreg_wb_arbiter.md
VREG_WB_ARBITER -- requirements
Module: vreg_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, lane width in bits; 4 lanes and 4 vector registers (2-bit index) are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid / alu_ready  input / output  1 / 1  requester 0 handshake: vector ALU full-vector write.
REQ-005 alu_vd, alu_w1..alu_w4  input  2 / DATA_W each  requester 0 destination register and lane data.
REQ-006 ld_valid / ld_ready  input / output  1 / 1  requester 1 handshake: vector load full-vector write.
REQ-007 ld_vd, ld_w1..ld_w4  input  2 / DATA_W each  requester 1 destination register and lane data.
REQ-008 im_valid / im_ready  input / output  1 / 1  requester 2 handshake: single-lane immediate write.
REQ-009 im_vd, im_vindex, im_imm  input  2 / 2 / DATA_W  requester 2 destination, lane, value.
REQ-010 rsv_valid / rsv_ready / rsv_vd  input / output / input  1 / 1 / 2  issue-time reservation of a destination register.
REQ-011 rd_valid, vs1, vs2  input  1 / 2 / 2  source registers of the instruction being issued.
REQ-012 hazard  output  1  combinational: rd_valid & (busy[vs1] | busy[vs2]).
REQ-013 write_enable, write_imm, vd, vindex, imm, vw1..vw4  output  1/1/2/2/DATA_W/DATA_W each  registered drive of the register bank write port.
REQ-014 busy  output  4  scoreboard, one bit per vector register.

Function
REQ-015 Handshake: transfer on requester i occurs on a rising edge where valid_i & ready_i; at most one transfer per cycle across all three requesters.
REQ-016 Eligibility: requester 0/1 eligible when valid; requester 2 eligible when im_valid & ~busy[im_vd].
REQ-017 Arbitration: round-robin over eligible requesters starting at pointer ptr (0..2); ready asserted combinationally only for the winner.
REQ-018 After a transfer by requester i, ptr <= (i+1) mod 3; ptr unchanged when no transfer.
REQ-019 Output stage: cycle after an ALU/load transfer, write_enable=1, write_imm=0, vd and vw1..vw4 = captured values; vindex, imm hold previous values.
REQ-020 Cycle after an immediate transfer, write_imm=1, write_enable=0, vd, vindex, imm = captured values; vw1..vw4 hold previous values.
REQ-021 write_enable and write_imm are single-cycle pulses, never both high; both 0 in any cycle following a no-transfer cycle.
REQ-022 Latency: request accepted at edge N, bank port driven during cycle N..N+1, bank write at edge N+1.
REQ-023 Scoreboard set: rsv_ready = ~busy[rsv_vd]; on rsv_valid & rsv_ready, busy[rsv_vd] <= 1.
REQ-024 Scoreboard clear: on the edge where write_enable=1, busy[vd] <= 0; write_imm does not clear.
REQ-025 Simultaneous set and clear of the same register in one cycle: set wins, bit remains 1.
REQ-026 A full-vector write to a register that is not busy is legal and leaves busy unchanged.
REQ-027 busy read by hazard and eligibility is the registered value (no same-cycle bypass of clear).
REQ-028 No requester starves: any continuously eligible requester is granted within 3 cycles.

Reset
REQ-029 On rst low, immediately: busy=0, ptr=0, write_enable=0, write_imm=0, vd=0, vindex=0, imm=0, vw1..vw4=0.
REQ-030 Reset mid-operation discards any captured transfer; no bank write pulse is emitted after reset release until a new transfer.
REQ-031 While rst low all ready outputs are 0; rsv_ready=1 is permitted only after release.

Verification
REQ-032 ALU alone: alu_valid=1, alu_vd=1, w1..w4=0x42080000/0x41600000/0x41680000/0x42AACCCD -> alu_ready=1 same cycle; next cycle write_enable=1, vd=1, vw1..vw4 equal inputs.
REQ-033 All three valid every cycle, im_vd not busy, ptr=0 -> grants in order ALU, load, imm, ALU; exactly one write pulse per cycle with matching type.
REQ-034 rsv_valid, rsv_vd=0 -> busy=0001; rd_valid, vs1=0, vs2=1 -> hazard=1; im_valid, im_vd=0 -> im_ready=0; ALU write vd=0 -> after pulse busy=0000, hazard=0, im_ready=1.
REQ-035 busy[2]=1, write_enable pulse vd=2 and rsv_valid rsv_vd=2 same cycle -> busy[2] stays 1; rsv_ready=0 for a second reservation of 2.
REQ-036 Immediate write im_vd=0, im_vindex=3, im_imm=0x4059999A -> next cycle write_imm=1, vd=0, vindex=3, imm=0x4059999A, write_enable=0.
REQ-037 Assert rst low in the cycle after an accepted ALU transfer -> write_enable=0 immediately, busy=0, ptr=0; after release no write pulse occurs.
